// File: rtl/sync_sp_ram_be_if.sv
// rtl/sync_sp_ram_be_if.sv - access bus for sync_sp_ram_be; ParErr_SO present with SYNC_SP_RAM_PARITY_EN
interface sync_sp_ram_be_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  localparam int NB = DATA_WIDTH / 8;

  logic                  CSel_SI;
  logic                  WrEn_SI;
  logic [NB-1:0]         BEn_SI;
  logic [ADDR_WIDTH-1:0] Addr_DI;
  logic [DATA_WIDTH-1:0] WrData_DI;
  logic [DATA_WIDTH-1:0] RdData_DO;
  logic                  RdValid_SO;
`ifdef SYNC_SP_RAM_PARITY_EN
  logic [NB-1:0]         ParErr_SO;

  modport master (
    output CSel_SI, WrEn_SI, BEn_SI, Addr_DI, WrData_DI,
    input  RdData_DO, RdValid_SO, ParErr_SO
  );
  modport slave (
    input  CSel_SI, WrEn_SI, BEn_SI, Addr_DI, WrData_DI,
    output RdData_DO, RdValid_SO, ParErr_SO
  );
`else
  modport master (
    output CSel_SI, WrEn_SI, BEn_SI, Addr_DI, WrData_DI,
    input  RdData_DO, RdValid_SO
  );
  modport slave (
    input  CSel_SI, WrEn_SI, BEn_SI, Addr_DI, WrData_DI,
    output RdData_DO, RdValid_SO
  );
`endif
endinterface

// File: rtl/sync_sp_ram_be.sv
// rtl/sync_sp_ram_be.sv - byte-enable single-port RAM with read-valid output pipeline
// Optional per-byte even parity: SYNC_SP_RAM_PARITY_EN
module sync_sp_ram_be #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_DEPTH = 1024,
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REGS   = 0,
  parameter int RDW_MODE   = 0
) (
  input  logic            Clk_CI,
  input  logic            Rst_RBI,
  sync_sp_ram_be_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;
`ifdef SYNC_SP_RAM_PARITY_EN
  // Parity bit of byte b is stored at word bit DATA_WIDTH+b
  localparam int W = DATA_WIDTH + NB;
`else
  localparam int W = DATA_WIDTH;
`endif
  localparam logic [ADDR_WIDTH:0] DEPTH_L = DATA_DEPTH[ADDR_WIDTH:0];

  if (DATA_WIDTH % 8 != 0) begin : g_err_width
    $error("sync_sp_ram_be: DATA_WIDTH must be a multiple of 8");
  end
  if ((64'd1 << ADDR_WIDTH) < 64'(DATA_DEPTH)) begin : g_err_depth
    $error("sync_sp_ram_be: ADDR_WIDTH too small for DATA_DEPTH");
  end
  if (OUT_REGS > 4) begin : g_err_oregs
    $error("sync_sp_ram_be: OUT_REGS must be 0..4");
  end
  if (RDW_MODE > 2) begin : g_err_rdw
    $error("sync_sp_ram_be: RDW_MODE must be 0..2");
  end

  logic [W-1:0]      mem_q [DATA_DEPTH];
  logic [W-1:0]      rd0_q, rd0_d;
  logic [W-1:0]      rd_out;
  logic [W-1:0]      old_word, new_word;
  logic [OUT_REGS:0] valid_q, valid_d;
  logic              in_range, rd_req, wr_req, mem_we;

  always_comb begin
    in_range = ({1'b0, bus.Addr_DI} < DEPTH_L);
    rd_req   = bus.CSel_SI & ~bus.WrEn_SI;
    wr_req   = bus.CSel_SI & bus.WrEn_SI;
    mem_we   = wr_req & in_range;
    old_word = in_range ? mem_q[bus.Addr_DI] : '0;
    new_word = old_word;
    for (int b = 0; b < NB; b++) begin
      if (bus.BEn_SI[b]) begin
        new_word[8*b +: 8] = bus.WrData_DI[8*b +: 8];
`ifdef SYNC_SP_RAM_PARITY_EN
        new_word[DATA_WIDTH + b] = ^bus.WrData_DI[8*b +: 8];
`endif
      end
    end
    // Out-of-range accesses return zeros, including write-first merges
    if (!in_range) new_word = '0;

    rd0_d = rd0_q;
    if (rd_req || (wr_req && RDW_MODE == 1)) rd0_d = old_word;
    else if (wr_req && RDW_MODE == 2)        rd0_d = new_word;

    valid_d[0] = rd_req | (wr_req & (RDW_MODE != 0));
    for (int k = 1; k <= OUT_REGS; k++) valid_d[k] = valid_q[k-1];
  end

  // Array and stage-0 register stay unreset so they map onto block RAM
  always_ff @(posedge Clk_CI) begin
    rd0_q <= rd0_d;
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.BEn_SI[b]) begin
          mem_q[bus.Addr_DI][8*b +: 8] <= bus.WrData_DI[8*b +: 8];
`ifdef SYNC_SP_RAM_PARITY_EN
          mem_q[bus.Addr_DI][DATA_WIDTH + b] <= new_word[DATA_WIDTH + b];
`endif
        end
      end
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) valid_q <= '0;
    else          valid_q <= valid_d;
  end

  if (OUT_REGS == 0) begin : g_nopipe
    assign rd_out = rd0_q;
  end else begin : g_pipe
    logic [W-1:0] pipe_q [OUT_REGS];
    logic [W-1:0] pipe_d [OUT_REGS];

    always_comb begin
      pipe_d[0] = valid_q[0] ? rd0_q : pipe_q[0];
      for (int k = 1; k < OUT_REGS; k++) pipe_d[k] = valid_q[k] ? pipe_q[k-1] : pipe_q[k];
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
        for (int k = 0; k < OUT_REGS; k++) pipe_q[k] <= '0;
      end else begin
        for (int k = 0; k < OUT_REGS; k++) pipe_q[k] <= pipe_d[k];
      end
    end

    assign rd_out = pipe_q[OUT_REGS-1];
  end

  assign bus.RdData_DO  = rd_out[DATA_WIDTH-1:0];
  assign bus.RdValid_SO = valid_q[OUT_REGS];

`ifdef SYNC_SP_RAM_PARITY_EN
  always_comb begin
    bus.ParErr_SO = '0;
    for (int b = 0; b < NB; b++) begin
      bus.ParErr_SO[b] = valid_q[OUT_REGS] & (^{rd_out[8*b +: 8], rd_out[DATA_WIDTH + b]});
    end
  end
`endif
endmodule

// File: tb/tb_sync_sp_ram_be.sv
// tb/tb_sync_sp_ram_be.sv - three RAM configurations checked against a word-level reference model
module tb_sync_sp_ram_be;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        cs, we;
  logic [3:0]  ben;
  logic [9:0]  addr;
  logic [31:0] wdata;

  sync_sp_ram_be_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus_a ();
  sync_sp_ram_be_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus_b ();
  sync_sp_ram_be_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus_c ();

  assign bus_a.CSel_SI = cs; assign bus_a.WrEn_SI = we; assign bus_a.BEn_SI = ben;
  assign bus_a.Addr_DI = addr; assign bus_a.WrData_DI = wdata;
  assign bus_b.CSel_SI = cs; assign bus_b.WrEn_SI = we; assign bus_b.BEn_SI = ben;
  assign bus_b.Addr_DI = addr; assign bus_b.WrData_DI = wdata;
  assign bus_c.CSel_SI = cs; assign bus_c.WrEn_SI = we; assign bus_c.BEn_SI = ben;
  assign bus_c.Addr_DI = addr; assign bus_c.WrData_DI = wdata;

  // a: no output regs, read-first; b: 2 regs, write-first; c: 3 regs, no-change
  sync_sp_ram_be #(.ADDR_WIDTH(10), .DATA_DEPTH(1000), .DATA_WIDTH(32), .OUT_REGS(0), .RDW_MODE(1))
    u_a (.Clk_CI(clk), .Rst_RBI(rst_n), .bus(bus_a));
  sync_sp_ram_be #(.ADDR_WIDTH(10), .DATA_DEPTH(1024), .DATA_WIDTH(32), .OUT_REGS(2), .RDW_MODE(2))
    u_b (.Clk_CI(clk), .Rst_RBI(rst_n), .bus(bus_b));
  sync_sp_ram_be #(.ADDR_WIDTH(10), .DATA_DEPTH(1000), .DATA_WIDTH(32), .OUT_REGS(3), .RDW_MODE(0))
    u_c (.Clk_CI(clk), .Rst_RBI(rst_n), .bus(bus_c));

  logic [31:0] rd [3];
  logic        vld [3];
  assign rd[0] = bus_a.RdData_DO; assign rd[1] = bus_b.RdData_DO; assign rd[2] = bus_c.RdData_DO;
  assign vld[0] = bus_a.RdValid_SO; assign vld[1] = bus_b.RdValid_SO; assign vld[2] = bus_c.RdValid_SO;
`ifdef SYNC_SP_RAM_PARITY_EN
  logic [3:0] perr [3];
  assign perr[0] = bus_a.ParErr_SO; assign perr[1] = bus_b.ParErr_SO; assign perr[2] = bus_c.ParErr_SO;
`endif

  function automatic int or_of(int i);    return (i == 0) ? 0 : (i == 1) ? 2 : 3;       endfunction
  function automatic int rdw_of(int i);   return (i == 0) ? 1 : (i == 1) ? 2 : 0;       endfunction
  function automatic int depth_of(int i); return (i == 1) ? 1024 : 1000;                endfunction

  function automatic logic [3:0] perr_of(logic [31:0] d, logic [3:0] p);
    logic [3:0] e;
    for (int b = 0; b < 4; b++) e[b] = (^d[8*b +: 8]) ^ p[b];
    return e;
  endfunction

  // Reference: memory contents, per-byte parity and a schedule of returned reads keyed by cycle
  logic [31:0] mmem   [3][1024];
  logic [3:0]  mpar   [3][1024];
  bit          mknown [3][1024];
  bit          s_vld  [3][8];
  bit          s_kn   [3][8];
  logic [31:0] s_dat  [3][8];
  logic [3:0]  s_perr [3][8];
  logic [31:0] last   [3];
  bit          last_known [3];
  bit          in_reset;
  int          cyc, n_tests, n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit inr, ok, give, dk;
    logic [31:0] od, nd, d;
    logic [3:0] op, np, p;
    int slot;
    for (int i = 0; i < 3; i++) begin
      inr = int'(addr) < depth_of(i);
      od  = inr ? mmem[i][addr] : 32'h0;
      op  = inr ? mpar[i][addr] : 4'h0;
      ok  = inr ? mknown[i][addr] : 1'b1;
      nd  = od;
      np  = op;
      for (int b = 0; b < 4; b++) begin
        if (ben[b]) begin
          nd[8*b +: 8] = wdata[8*b +: 8];
          np[b] = ^wdata[8*b +: 8];
        end
      end
      give = 1'b0; d = od; p = op; dk = ok;
      if (cs && !we) give = 1'b1;
      else if (cs && we && rdw_of(i) == 1) give = 1'b1;
      else if (cs && we && rdw_of(i) == 2) begin
        give = 1'b1;
        d  = inr ? nd : 32'h0;
        p  = inr ? np : 4'h0;
        dk = !inr || ok || (ben == 4'hF);
      end
      if (!in_reset) begin
        slot = (cyc + or_of(i)) % 8;
        s_vld[i][slot]  = give;
        s_dat[i][slot]  = d;
        s_kn[i][slot]   = dk;
        s_perr[i][slot] = perr_of(d, p);
      end
      if (cs && we && inr) begin
        mmem[i][addr]   = nd;
        mpar[i][addr]   = np;
        mknown[i][addr] = ok || (ben == 4'hF);
      end
    end
  endtask

  task automatic compare();
    int slot;
    slot = cyc % 8;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("valid[%0d]@%0d", i, cyc), 32'(vld[i]), 32'(s_vld[i][slot]));
      if (s_vld[i][slot]) begin
        last[i] = s_dat[i][slot];
        last_known[i] = s_kn[i][slot];
      end
      if (last_known[i]) check($sformatf("data[%0d]@%0d", i, cyc), rd[i], last[i]);
`ifdef SYNC_SP_RAM_PARITY_EN
      if (!s_vld[i][slot] || s_kn[i][slot])
        check($sformatf("parerr[%0d]@%0d", i, cyc), 32'(perr[i]),
              s_vld[i][slot] ? 32'(s_perr[i][slot]) : 32'h0);
`endif
      s_vld[i][slot] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    cyc++;
  endtask

  task automatic acc(input bit c, input bit w, input logic [3:0] be, input logic [9:0] a,
                     input logic [31:0] d);
    cs = c; we = w; ben = be; addr = a; wdata = d;
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) acc(1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
  endtask

  task automatic clear_sched();
    for (int i = 0; i < 3; i++) begin
      for (int s = 0; s < 8; s++) s_vld[i][s] = 1'b0;
      last[i] = 32'h0;
      last_known[i] = (or_of(i) > 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b0; in_reset = 1'b1;
    cs = 1'b0; we = 1'b0; ben = 4'h0; addr = 10'h0; wdata = 32'h0;
    for (int i = 0; i < 3; i++)
      for (int a = 0; a < 1024; a++) mknown[i][a] = 1'b0;
    clear_sched();

    idle(3);
    rst_n = 1'b1; in_reset = 1'b0;

    for (int a = 0; a < 1024; a++) acc(1'b1, 1'b1, 4'hF, 10'(a), $urandom);

    acc(1'b1, 1'b1, 4'hF, 10'd5, 32'hDEADBEEF);
    acc(1'b1, 1'b0, 4'h0, 10'd5, 32'h0);
    idle(4);
    for (int i = 0; i < 3; i++) check($sformatf("deadbeef[%0d]", i), rd[i], 32'hDEADBEEF);

    acc(1'b1, 1'b1, 4'hF, 10'd3, 32'h11223344);
    acc(1'b1, 1'b1, 4'b0101, 10'd3, 32'hAABBCCDD);
    acc(1'b1, 1'b0, 4'h0, 10'd3, 32'h0);
    idle(5);
    for (int i = 0; i < 3; i++) check($sformatf("bytemerge[%0d]", i), rd[i], 32'h11BB33DD);

    acc(1'b1, 1'b1, 4'hF, 10'd7, 32'h0);
    acc(1'b1, 1'b1, 4'b0011, 10'd7, 32'hFFFFFFFF);
    idle(4);
    check("rdw_read_first", rd[0], 32'h00000000);
    check("rdw_write_first", rd[1], 32'h0000FFFF);
    check("rdw_no_change", rd[2], 32'h11BB33DD);
    acc(1'b1, 1'b0, 4'h0, 10'd7, 32'h0);
    idle(4);

    acc(1'b1, 1'b1, 4'hF, 10'd1020, 32'hCAFEF00D);
    acc(1'b1, 1'b0, 4'h0, 10'd1020, 32'h0);
    idle(4);
    check("oob_read_a", rd[0], 32'h0);
    check("oob_read_c", rd[2], 32'h0);
    acc(1'b1, 1'b0, 4'h0, 10'd999, 32'h0);
    idle(4);

    acc(1'b1, 1'b0, 4'h0, 10'd10, 32'h0);
    acc(1'b1, 1'b0, 4'h0, 10'd11, 32'h0);
    rst_n = 1'b0; in_reset = 1'b1;
    #2;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_valid[%0d]", i), 32'(vld[i]), 32'h0);
      if (or_of(i) > 0) check($sformatf("rst_data[%0d]", i), rd[i], 32'h0);
    end
    clear_sched();
    acc(1'b1, 1'b0, 4'h0, 10'd12, 32'h0);
    acc(1'b1, 1'b0, 4'h0, 10'd13, 32'h0);
    idle(2);
    rst_n = 1'b1; in_reset = 1'b0;
    idle(6);
    for (int a = 10; a < 14; a++) acc(1'b1, 1'b0, 4'h0, 10'(a), 32'h0);
    idle(5);

`ifdef SYNC_SP_RAM_PARITY_EN
    u_a.mem_q[2][9] <= ~u_a.mem_q[2][9];
    mmem[0][2][9] = ~mmem[0][2][9];
    #1;
    acc(1'b1, 1'b0, 4'h0, 10'd2, 32'h0);
    check("parity_flip", 32'(perr[0]), 32'h2);
    idle(4);
`endif

    for (int n = 0; n < 3000; n++) begin
      logic [9:0] a;
      a = ($urandom_range(0, 3) == 0) ? 10'(990 + $urandom_range(0, 33)) : 10'($urandom_range(0, 15));
      acc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom), a, $urandom);
    end
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
